// File: rtl/fetch_decode_controller_pkg.sv
// ---------------------------------------------------------------------------
// fetch_decode_controller_pkg : state encodings, opcodes and control codes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_decode_controller_pkg;

  typedef enum logic [1:0] {
    ST_FETCH_L = 2'b00,
    ST_FETCH_H = 2'b01,
    ST_EXEC    = 2'b10,
    ST_HALT    = 2'b11
  } state_e;

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_LDI = 6'h02;
  localparam logic [5:0] OP_ADD = 6'h03;
  localparam logic [5:0] OP_HLT = 6'h04;

  localparam logic [2:0] RF_FUN_LOAD   = 3'b010;
  localparam logic [2:0] ARF_FUN_INC   = 3'b001;
  localparam logic [2:0] ARF_FUN_LOAD  = 3'b010;
  localparam logic [4:0] ALU_FUN_ADD16 = 5'b10100;

  localparam logic [1:0] MUX_ALU_OUT = 2'b00;
  localparam logic [1:0] MUX_IR_LO   = 2'b11;
  localparam logic [1:0] ARF_SEL_PC  = 2'b00;
  localparam logic [2:0] ARF_EN_PC   = 3'b100;

  // Complete control word; field order is shared with the bench
  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [2:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] muxa_sel;
    logic [1:0] muxb_sel;
    logic       muxc_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mem_cs: 1'b1, default: '0};

  // Register index 0 (R1) maps to enable bit 3
  function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_decode_controller_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_controller_if : sequencer <-> datapath control bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_decode_controller_if;
  logic [15:0] IROut;
  logic [3:0]  FlagsOut;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [2:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Write;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [1:0]  State;
  logic        Halted;

  modport master (
    input  IROut, FlagsOut,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    output ALU_FunSel, ALU_WF,
    output ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    output IR_LH, IR_Write, Mem_WR, Mem_CS,
    output MuxASel, MuxBSel, MuxCSel, State, Halted
  );

  modport slave (
    output IROut, FlagsOut,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
    input  ALU_FunSel, ALU_WF,
    input  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
    input  IR_LH, IR_Write, Mem_WR, Mem_CS,
    input  MuxASel, MuxBSel, MuxCSel, State, Halted
  );
endinterface

`default_nettype wire

// File: rtl/fetch_decode_controller.sv
// ---------------------------------------------------------------------------
// fetch_decode_controller : 3-cycle fetch/fetch/execute sequencer and decoder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_decode_controller
  import fetch_decode_controller_pkg::*;
(
  input  wire logic                  Clock,
  input  wire logic                  Reset,
  fetch_decode_controller_if.master  bus
);

  state_e      r_state;
  ctrl_t       w_ctrl;
  logic [5:0]  w_opcode;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs1;
  logic [1:0]  w_rs2;
  logic        w_zero;
  logic        w_take_branch;
  logic        w_unused;

  assign w_opcode = bus.IROut[15:10];
  assign w_rd     = bus.IROut[9:8];
  assign w_rs1    = bus.IROut[5:4];
  assign w_rs2    = bus.IROut[1:0];
  assign w_zero   = bus.FlagsOut[3];
  assign w_unused = ^bus.FlagsOut[2:0];

  assign w_take_branch = (w_opcode == OP_BRA) ||
                         ((w_opcode == OP_BNE) && !w_zero);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_FETCH_L;
    end else begin
      case (r_state)
        ST_FETCH_L: r_state <= ST_FETCH_H;
        ST_FETCH_H: r_state <= ST_EXEC;
        ST_EXEC:    r_state <= (w_opcode == OP_HLT) ? ST_HALT : ST_FETCH_L;
        ST_HALT:    r_state <= ST_HALT;
        default:    r_state <= ST_FETCH_L;
      endcase
    end
  end

  // Reset gates the decode so FETCH_L's non-idle controls never leak out
  // while the sequencer is held in reset.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (Reset) begin
      case (r_state)
        ST_FETCH_L, ST_FETCH_H: begin
          w_ctrl.arf_outd_sel = ARF_SEL_PC;
          w_ctrl.mem_cs       = 1'b0;
          w_ctrl.ir_write     = 1'b1;
          w_ctrl.ir_lh        = (r_state == ST_FETCH_H);
          w_ctrl.arf_reg_sel  = ARF_EN_PC;
          w_ctrl.arf_fun_sel  = ARF_FUN_INC;
        end
        ST_EXEC: begin
          if (w_take_branch) begin
            w_ctrl.muxb_sel    = MUX_IR_LO;
            w_ctrl.arf_fun_sel = ARF_FUN_LOAD;
            w_ctrl.arf_reg_sel = ARF_EN_PC;
          end else if (w_opcode == OP_LDI) begin
            w_ctrl.muxa_sel   = MUX_IR_LO;
            w_ctrl.rf_fun_sel = RF_FUN_LOAD;
            w_ctrl.rf_reg_sel = rf_onehot(w_rd);
          end else if (w_opcode == OP_ADD) begin
            w_ctrl.rf_outa_sel = {1'b0, w_rs1};
            w_ctrl.rf_outb_sel = {1'b0, w_rs2};
            w_ctrl.alu_fun_sel = ALU_FUN_ADD16;
            w_ctrl.alu_wf      = 1'b1;
            w_ctrl.muxa_sel    = MUX_ALU_OUT;
            w_ctrl.rf_fun_sel  = RF_FUN_LOAD;
            w_ctrl.rf_reg_sel  = rf_onehot(w_rd);
          end
        end
        default: w_ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign bus.RF_OutASel  = w_ctrl.rf_outa_sel;
  assign bus.RF_OutBSel  = w_ctrl.rf_outb_sel;
  assign bus.RF_FunSel   = w_ctrl.rf_fun_sel;
  assign bus.RF_RegSel   = w_ctrl.rf_reg_sel;
  assign bus.RF_ScrSel   = w_ctrl.rf_scr_sel;
  assign bus.ALU_FunSel  = w_ctrl.alu_fun_sel;
  assign bus.ALU_WF      = w_ctrl.alu_wf;
  assign bus.ARF_OutCSel = w_ctrl.arf_outc_sel;
  assign bus.ARF_OutDSel = w_ctrl.arf_outd_sel;
  assign bus.ARF_FunSel  = w_ctrl.arf_fun_sel;
  assign bus.ARF_RegSel  = w_ctrl.arf_reg_sel;
  assign bus.IR_LH       = w_ctrl.ir_lh;
  assign bus.IR_Write    = w_ctrl.ir_write;
  assign bus.Mem_WR      = w_ctrl.mem_wr;
  assign bus.Mem_CS      = w_ctrl.mem_cs;
  assign bus.MuxASel     = w_ctrl.muxa_sel;
  assign bus.MuxBSel     = w_ctrl.muxb_sel;
  assign bus.MuxCSel     = w_ctrl.muxc_sel;
  assign bus.State       = r_state;
  assign bus.Halted      = (r_state == ST_HALT);

  a_no_mem_write: assert property (@(posedge Clock) disable iff (!Reset)
    !bus.Mem_WR);
  a_rf_onehot: assert property (@(posedge Clock) disable iff (!Reset)
    $onehot0(bus.RF_RegSel));

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_controller : ISA-model scoreboard bench with a toy datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_decode_controller;
  import fetch_decode_controller_pkg::*;

  typedef struct packed {
    logic [1:0] st;
    logic       halted;
    ctrl_t      c;
  } obs_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  fetch_decode_controller_if bus();

  fetch_decode_controller dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Toy datapath driven by the controller
  logic [7:0]  mem [256];
  logic [15:0] pc, ir;
  logic [15:0] rf [4];
  logic        z;
  logic [2:0]  cno;

  assign bus.IROut    = ir;
  assign bus.FlagsOut = {z, cno};

  always @(posedge Clock) begin : datapath
    logic [15:0] alu;
    alu = rf[bus.RF_OutASel[1:0]] + rf[bus.RF_OutBSel[1:0]];
    if (!bus.Mem_CS && bus.IR_Write) begin
      if (bus.IR_LH) ir[15:8] <= mem[pc[7:0]];
      else           ir[7:0]  <= mem[pc[7:0]];
    end
    if (bus.ARF_RegSel[2]) begin
      if (bus.ARF_FunSel == 3'b001) pc <= pc + 16'd1;
      else if (bus.ARF_FunSel == 3'b010)
        pc <= (bus.MuxBSel == 2'b11) ? {8'h00, ir[7:0]} : 16'hDEAD;
    end
    if (bus.RF_FunSel == 3'b010) begin
      for (int i = 0; i < 4; i++)
        if (bus.RF_RegSel[3-i])
          rf[i] <= (bus.MuxASel == 2'b11) ? {8'h00, ir[7:0]} :
                   (bus.MuxASel == 2'b00) ? alu : 16'hDEAD;
    end
    if (bus.ALU_WF) z <= (alu == 16'h0000);
    cno <= 3'($urandom);
  end

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  int   prog_id = 0;
  obs_t exp_q [$];
  logic [15:0] exp_pc;
  logic [15:0] exp_rf [4];
  logic        exp_z;

  function automatic ctrl_t idle_vec();
    ctrl_t c;
    c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t fetch_vec(input logic lh);
    ctrl_t c;
    c = idle_vec();
    c.arf_outd_sel = 2'b00;
    c.mem_cs       = 1'b0;
    c.ir_write     = 1'b1;
    c.ir_lh        = lh;
    c.arf_reg_sel  = 3'b100;
    c.arf_fun_sel  = 3'b001;
    return c;
  endfunction

  function automatic ctrl_t exec_vec(input logic [15:0] w, input logic zf);
    ctrl_t c;
    c = idle_vec();
    if (w[15:10] == 6'h00 || (w[15:10] == 6'h01 && !zf)) begin
      c.muxb_sel = 2'b11; c.arf_fun_sel = 3'b010; c.arf_reg_sel = 3'b100;
    end else if (w[15:10] == 6'h02) begin
      c.muxa_sel = 2'b11; c.rf_fun_sel = 3'b010; c.rf_reg_sel = 4'b1000 >> w[9:8];
    end else if (w[15:10] == 6'h03) begin
      c.rf_outa_sel = {1'b0, w[5:4]}; c.rf_outb_sel = {1'b0, w[1:0]};
      c.alu_fun_sel = 5'b10100; c.alu_wf = 1'b1; c.muxa_sel = 2'b00;
      c.rf_fun_sel  = 3'b010;   c.rf_reg_sel = 4'b1000 >> w[9:8];
    end
    return c;
  endfunction

  function automatic obs_t sample_bus();
    obs_t o;
    o.st = bus.State;         o.halted = bus.Halted;
    o.c.rf_outa_sel  = bus.RF_OutASel;  o.c.rf_outb_sel = bus.RF_OutBSel;
    o.c.rf_fun_sel   = bus.RF_FunSel;   o.c.rf_reg_sel  = bus.RF_RegSel;
    o.c.rf_scr_sel   = bus.RF_ScrSel;   o.c.alu_fun_sel = bus.ALU_FunSel;
    o.c.alu_wf       = bus.ALU_WF;      o.c.arf_outc_sel = bus.ARF_OutCSel;
    o.c.arf_outd_sel = bus.ARF_OutDSel; o.c.arf_fun_sel = bus.ARF_FunSel;
    o.c.arf_reg_sel  = bus.ARF_RegSel;  o.c.ir_lh = bus.IR_LH;
    o.c.ir_write     = bus.IR_Write;    o.c.mem_wr = bus.Mem_WR;
    o.c.mem_cs       = bus.Mem_CS;      o.c.muxa_sel = bus.MuxASel;
    o.c.muxb_sel     = bus.MuxBSel;     o.c.muxc_sel = bus.MuxCSel;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s prog=%0d actual=%h required=%h", name, prog_id, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected observation per cycle while enabled
  initial begin
    forever begin
      @(negedge Clock);
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow prog=%0d actual=%h required=none",
                   prog_id, sample_bus());
        end else begin
          obs_t e, a;
          e = exp_q.pop_front();
          a = sample_bus();
          if (a !== e) begin
            errors++;
            $display("FAIL cycle_ctrl prog=%0d t=%0t actual=%h required=%h",
                     prog_id, $time, a, e);
          end
        end
      end
    end
  end

  // Instruction-level reference: three observations per instruction
  task automatic build_expect();
    logic [15:0] m_pc, w, sum;
    logic [15:0] m_rf [4];
    logic        m_z, done;
    logic [7:0]  ia;
    m_pc = 16'h0000; m_z = z; done = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = rf[i];
    for (int n = 0; n < 200 && !done; n++) begin
      ia = m_pc[7:0];
      w  = {mem[ia + 8'd1], mem[ia]};
      exp_q.push_back({2'b00, 1'b0, fetch_vec(1'b0)});
      exp_q.push_back({2'b01, 1'b0, fetch_vec(1'b1)});
      exp_q.push_back({2'b10, 1'b0, exec_vec(w, m_z)});
      m_pc = m_pc + 16'd2;
      case (w[15:10])
        6'h00: m_pc = {8'h00, w[7:0]};
        6'h01: if (!m_z) m_pc = {8'h00, w[7:0]};
        6'h02: m_rf[w[9:8]] = {8'h00, w[7:0]};
        6'h03: begin
          sum = m_rf[w[5:4]] + m_rf[w[1:0]];
          m_rf[w[9:8]] = sum;
          m_z = (sum == 16'h0000);
        end
        6'h04: done = 1'b1;
        default: ;
      endcase
    end
    for (int k = 0; k < 20; k++) exp_q.push_back({2'b11, 1'b1, idle_vec()});
    exp_pc = m_pc; exp_z = m_z;
    for (int i = 0; i < 4; i++) exp_rf[i] = m_rf[i];
  endtask

  task automatic put_word(input int a, input logic [15:0] w);
    mem[a] = w[7:0];
    mem[a+1] = w[15:8];
  endtask

  // Branches only jump forward so every program reaches a HLT
  function automatic logic [15:0] gen_word(input int a);
    int r, t;
    r = int'($urandom_range(0, 31));
    t = a + 2 + 2 * int'($urandom_range(0, 6));
    if (t > 240) t = 240;
    if (r <= 8)
      return {6'h02, 2'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)};
    if (r <= 16 || (r >= 28 && r <= 30)) return {6'h03, 10'($urandom)};
    if (r <= 20) return {6'h01, 2'($urandom), 8'(t)};
    if (r <= 22) return {6'h00, 2'($urandom), 8'(t)};
    if (r <= 27) return {6'($urandom_range(5, 63)), 10'($urandom)};
    return {6'h04, 10'($urandom)};
  endfunction

  task automatic load_mem(input int p);
    for (int a = 0; a < 256; a += 2) put_word(a, 16'h1000);
    if (p == 0) begin
      put_word(0, 16'h082A);    put_word(2, 16'h0905);
      put_word(4, 16'h0A07);    put_word(6, 16'h0C12);
      put_word(8, 16'h0440);    put_word(8'h40, 16'hFC00);
      put_word(8'h42, 16'h0B00); put_word(8'h44, 16'h0F33);
      put_word(8'h46, 16'h0480); put_word(8'h48, 16'h0050);
    end else begin
      for (int a = 0; a < 240; a += 2) put_word(a, gen_word(a));
    end
  endtask

  task automatic run_program(input int p);
    int n;
    prog_id = p;
    load_mem(p);
    pc = 16'h0000; ir = 16'($urandom); z = 1'($urandom);
    for (int i = 0; i < 4; i++) rf[i] = 16'($urandom);
    build_expect();
    @(posedge Clock); #1;
    Reset  = 1'b1;
    mon_en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge Clock);
      n++;
    end
    #1 mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL program_timeout prog=%0d actual=%0d required=0 pending", p, exp_q.size());
      exp_q.delete();
    end
    check("final_pc", 64'(pc), 64'(exp_pc));
    for (int i = 0; i < 4; i++) check("final_rf", 64'(rf[i]), 64'(exp_rf[i]));
    check("final_z", 64'(z), 64'(exp_z));
    check("halted_before_reset", 64'(bus.Halted), 64'd1);
    Reset = 1'b0;
    #1;
    check("async_reset_from_halt", 64'(sample_bus()), 64'({2'b00, 1'b0, idle_vec()}));
  endtask

  initial begin
    pc = '0; ir = '0; z = 1'b0; cno = '0;
    for (int i = 0; i < 4; i++) rf[i] = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_idle", 64'(sample_bus()), 64'({2'b00, 1'b0, idle_vec()}));

    for (int p = 0; p < 8; p++) run_program(p);

    // Reset asserted during FETCH_H, between clock edges
    prog_id = 100;
    load_mem(0);
    pc = 16'h0000;
    @(posedge Clock); #1 Reset = 1'b1;
    @(posedge Clock); #1;
    check("fetch_h_before_reset", 64'(sample_bus()), 64'({2'b01, 1'b0, fetch_vec(1'b1)}));
    #1 Reset = 1'b0;
    #1;
    check("mid_fetch_reset_idle", 64'(sample_bus()), 64'({2'b00, 1'b0, idle_vec()}));
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    check("after_release_fetch_l", 64'(sample_bus()), 64'({2'b00, 1'b0, fetch_vec(1'b0)}));
    @(posedge Clock); #1;
    check("after_release_state", 64'(bus.State), 64'(2'b01));
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
